// File: rtl/keycode_tone_voice.sv
// -----------------------------------------------------------------------------
// keycode_tone_voice
//
// Voice stage that follows the scripted-melody sequencer. Every change on the
// incoming scan-code stream is an event: a note code retriggers a pitched
// square wave with a linear attack, and the release code 8'hf0 starts a linear
// release. The envelope and the phase accumulator advance once per
// sample_tick. One signed 16-bit sample is produced per tick, one clock later.
//
// Ports
//   clock        in   1   system clock, all state on posedge
//   k_tr         in   1   asynchronous active-low reset
//   key_code     in   8   scan code from the sequencer (held for many clocks)
//   sample_tick  in   1   one-clock audio sample strobe
//   sample       out  16  signed audio sample (+/- env*128, 0 when idle)
//   env          out  8   current envelope level
//   note_on      out  1   high while the voice is attacking or sustaining
//   busy         out  1   high while the voice is not idle
// -----------------------------------------------------------------------------
module keycode_tone_voice #(
    parameter int ACC_W    = 24,
    parameter int ATK_STEP = 8,
    parameter int REL_STEP = 2
) (
    input  logic               clock,
    input  logic               k_tr,
    input  logic [7:0]         key_code,
    input  logic               sample_tick,
    output logic signed [15:0] sample,
    output logic [7:0]         env,
    output logic               note_on,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] KEY_RELEASE = 8'hf0;
    localparam logic [7:0] ENV_MAX     = 8'd255;

    // True when the scan code is one of the eight playable notes.
    function automatic logic code_is_note(input logic [7:0] code);
        logic hit;
        case (code)
            8'h2b, 8'h34, 8'h33, 8'h3b,
            8'h42, 8'h4b, 8'h4c, 8'h52: hit = 1'b1;
            default:                    hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Phase increment per sample for each note (48 kHz sample rate, 24-bit
    // accumulator); unmapped codes return zero and are never loaded.
    function automatic logic [ACC_W-1:0] code_to_inc(input logic [7:0] code);
        logic [ACC_W-1:0] val;
        case (code)
            8'h2b:   val = ACC_W'(24'd91447);
            8'h34:   val = ACC_W'(24'd102642);
            8'h33:   val = ACC_W'(24'd115214);
            8'h3b:   val = ACC_W'(24'd122065);
            8'h42:   val = ACC_W'(24'd137014);
            8'h4b:   val = ACC_W'(24'd153791);
            8'h4c:   val = ACC_W'(24'd172624);
            8'h52:   val = ACC_W'(24'd182889);
            default: val = '0;
        endcase
        return val;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         key_prev_r;
    logic [ACC_W-1:0]   inc_r;
    logic [ACC_W-1:0]   inc_s;
    logic [ACC_W-1:0]   phase_r;
    logic [ACC_W-1:0]   phase_s;
    logic [7:0]         env_r;
    logic [7:0]         env_s;
    logic               tick_d_r;
    logic signed [15:0] sample_r;
    logic signed [15:0] sample_s;
    logic               note_on_r;
    logic               busy_r;

    logic               event_s;
    logic [8:0]         env_sum_s;
    logic [15:0]        mag_s;

    assign event_s = (key_code != key_prev_r);

    // Next-state logic: apply the key event first, then the per-tick envelope
    // and phase step using the post-event state and increment.
    always_comb begin
        state_s   = state_r;
        inc_s     = inc_r;
        phase_s   = phase_r;
        env_s     = env_r;
        env_sum_s = {1'b0, env_r} + 9'(ATK_STEP);

        if (event_s) begin
            if (code_is_note(key_code)) begin
                // Retrigger keeps the current level; only a fresh note from
                // silence restarts the waveform at phase zero.
                if (state_r == ST_IDLE) begin
                    phase_s = '0;
                end else begin
                    phase_s = phase_r;
                end
                state_s = ST_ATTACK;
                inc_s   = code_to_inc(key_code);
            end else if ((key_code == KEY_RELEASE) &&
                         ((state_r == ST_ATTACK) || (state_r == ST_SUSTAIN))) begin
                state_s = ST_RELEASE;
            end else begin
                state_s = state_r;
            end
        end else begin
            state_s = state_r;
        end

        if (sample_tick) begin
            case (state_s)
                ST_ATTACK: begin
                    if (env_sum_s >= {1'b0, ENV_MAX}) begin
                        env_s   = ENV_MAX;
                        state_s = ST_SUSTAIN;
                    end else begin
                        env_s   = env_sum_s[7:0];
                    end
                    phase_s = phase_s + inc_s;
                end
                ST_SUSTAIN: begin
                    env_s   = ENV_MAX;
                    phase_s = phase_s + inc_s;
                end
                ST_RELEASE: begin
                    if (env_r <= 8'(REL_STEP)) begin
                        env_s   = 8'd0;
                        state_s = ST_IDLE;
                        phase_s = '0;
                    end else begin
                        env_s   = env_r - 8'(REL_STEP);
                        phase_s = phase_s + inc_s;
                    end
                end
                ST_IDLE: begin
                    env_s = env_r;
                end
                default: begin
                    env_s   = 8'd0;
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            env_s = env_r;
        end
    end

    // Sample value from the state updated on the tick edge: +/- env*128 by the
    // accumulator MSB, silent when idle; it only refreshes the clock after a tick.
    always_comb begin
        mag_s    = {1'b0, env_r, 7'd0};
        sample_s = sample_r;
        if (tick_d_r) begin
            if (state_r == ST_IDLE) begin
                sample_s = 16'sd0;
            end else if (phase_r[ACC_W-1]) begin
                sample_s = $signed(mag_s);
            end else begin
                sample_s = $signed(16'd0 - mag_s);
            end
        end else begin
            sample_s = sample_r;
        end
    end

    // State, envelope, phase and registered outputs.
    always_ff @(posedge clock or negedge k_tr) begin
        if (!k_tr) begin
            state_r    <= ST_IDLE;
            key_prev_r <= KEY_RELEASE;
            inc_r      <= '0;
            phase_r    <= '0;
            env_r      <= 8'd0;
            tick_d_r   <= 1'b0;
            sample_r   <= 16'sd0;
            note_on_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            key_prev_r <= key_code;
            inc_r      <= inc_s;
            phase_r    <= phase_s;
            env_r      <= env_s;
            tick_d_r   <= sample_tick;
            sample_r   <= sample_s;
            note_on_r  <= (state_s == ST_ATTACK) || (state_s == ST_SUSTAIN);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign sample  = sample_r;
    assign env     = env_r;
    assign note_on = note_on_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_keycode_tone_voice.sv
module tb_keycode_tone_voice;

    logic               clock;
    logic               k_tr;
    logic [7:0]         key_code;
    logic               sample_tick;
    logic signed [15:0] sample;
    logic [7:0]         env;
    logic               note_on;
    logic               busy;

    int tests_run;
    int tests_failed;

    logic [23:0] exp_phase;
    int          exp_env;
    logic [23:0] exp_inc;

    keycode_tone_voice #(.ACC_W(24), .ATK_STEP(8), .REL_STEP(2)) dut (
        .clock       (clock),
        .k_tr        (k_tr),
        .key_code    (key_code),
        .sample_tick (sample_tick),
        .sample      (sample),
        .env         (env),
        .note_on     (note_on),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample strobe; returns at a negedge where the delayed sample is valid.
    task automatic do_tick();
        @(negedge clock) sample_tick = 1'b1;
        @(negedge clock) sample_tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic set_key(input logic [7:0] code);
        @(negedge clock) key_code = code;
        @(negedge clock);
    endtask

    function automatic int exp_sample(input logic idle, input logic [23:0] ph,
                                      input int e);
        if (idle) return 0;
        return ph[23] ? (e * 128) : -(e * 128);
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        k_tr         = 1'b0;
        key_code     = 8'hf0;
        sample_tick  = 1'b0;

        // 1: reset values, then attack to sustain on 2b
        repeat (2) @(negedge clock);
        chk("rst_sample",  sample,      0);
        chk("rst_env",     env,         0);
        chk("rst_note_on", note_on,     0);
        chk("rst_busy",    busy,        0);
        chk("rst_phase",   dut.phase_r, 0);
        k_tr = 1'b1;

        set_key(8'h2b);
        exp_inc = 24'd91447; exp_phase = 24'd0; exp_env = 0;
        chk("atk_busy",    busy,      1);
        chk("atk_note_on", note_on,   1);
        chk("atk_env0",    env,       0);
        chk("atk_inc",     dut.inc_r, exp_inc);
        for (int k = 1; k <= 40; k++) begin
            do_tick();
            exp_env   = (exp_env + 8 > 255) ? 255 : exp_env + 8;
            exp_phase = exp_phase + exp_inc;
            chk($sformatf("atk_env_t%0d", k), env, exp_env);
            chk($sformatf("atk_smp_t%0d", k), sample, exp_sample(1'b0, exp_phase, exp_env));
        end
        chk("sus_note_on", note_on,     1);
        chk("sus_phase",   dut.phase_r, exp_phase);

        // 2: release to silence in 128 ticks
        set_key(8'hf0);
        chk("rel_note_on", note_on, 0);
        chk("rel_busy",    busy,    1);
        for (int k = 1; k <= 128; k++) begin
            do_tick();
            exp_env   = (exp_env - 2 < 0) ? 0 : exp_env - 2;
            exp_phase = (exp_env == 0) ? 24'd0 : exp_phase + exp_inc;
            if (k == 127) begin
                chk("rel_env_127",  env,  1);
                chk("rel_busy_127", busy, 1);
            end
        end
        chk("idle_env",    env,         0);
        chk("idle_busy",   busy,        0);
        chk("idle_sample", sample,      0);
        chk("idle_phase",  dut.phase_r, 0);

        // 3: held code gives a single event, no ticks -> level stays 0
        set_key(8'h2b);
        repeat (1000) @(negedge clock);
        chk("hold_env",     env,         0);
        chk("hold_busy",    busy,        1);
        chk("hold_note_on", note_on,     1);
        chk("hold_phase",   dut.phase_r, 0);

        // 4: retrigger during release at env=100
        exp_env = 0; exp_phase = 24'd0;
        for (int k = 1; k <= 13; k++) begin
            do_tick();
            exp_env = exp_env + 8; exp_phase = exp_phase + exp_inc;
        end
        chk("pre_rel_env", env, 104);
        set_key(8'hf0);
        repeat (2) begin
            do_tick();
            exp_env = exp_env - 2; exp_phase = exp_phase + exp_inc;
        end
        chk("rel100_env",     env,     100);
        chk("rel100_note_on", note_on, 0);
        set_key(8'h52);
        exp_inc = 24'd182889;
        chk("retrig_env",     env,         100);
        chk("retrig_note_on", note_on,     1);
        chk("retrig_inc",     dut.inc_r,   exp_inc);
        chk("retrig_phase",   dut.phase_r, exp_phase);
        do_tick();
        exp_env = exp_env + 8; exp_phase = exp_phase + exp_inc;
        chk("retrig_env_t1",   env,         108);
        chk("retrig_phase_t1", dut.phase_r, exp_phase);
        chk("retrig_smp_t1",   sample,      exp_sample(1'b0, exp_phase, exp_env));

        // 5: unmapped code in sustain, then f0 while idle
        for (int k = 1; k <= 19; k++) begin
            do_tick();
            exp_env = (exp_env + 8 > 255) ? 255 : exp_env + 8;
            exp_phase = exp_phase + exp_inc;
        end
        chk("sus2_env", env, 255);
        set_key(8'h1f);
        chk("unmap_env",     env,       255);
        chk("unmap_inc",     dut.inc_r, exp_inc);
        chk("unmap_note_on", note_on,   1);
        do_tick();
        exp_phase = exp_phase + exp_inc;
        chk("unmap_env_t",   env,         255);
        chk("unmap_phase_t", dut.phase_r, exp_phase);
        set_key(8'hf0);
        repeat (128) do_tick();
        chk("idle2_busy", busy, 0);
        set_key(8'h1f);
        set_key(8'hf0);
        chk("f0idle_busy",    busy,    0);
        chk("f0idle_note_on", note_on, 0);
        chk("f0idle_env",     env,     0);

        // simultaneous code event and sample tick from idle
        @(negedge clock) begin key_code = 8'h2b; sample_tick = 1'b1; end
        @(negedge clock) sample_tick = 1'b0;
        @(negedge clock);
        exp_inc = 24'd91447; exp_phase = exp_inc; exp_env = 8;
        chk("simul_env",     env,         8);
        chk("simul_note_on", note_on,     1);
        chk("simul_phase",   dut.phase_r, exp_phase);
        chk("simul_sample",  sample,      -1024);

        // 6: reset mid-attack, between ticks
        repeat (4) begin
            do_tick();
            exp_env = exp_env + 8; exp_phase = exp_phase + exp_inc;
        end
        chk("pre_rst_env",    env,    40);
        chk("pre_rst_sample", sample, exp_sample(1'b0, exp_phase, exp_env));
        #2 k_tr = 1'b0;
        #1;
        chk("mid_rst_sample",  sample,      0);
        chk("mid_rst_env",     env,         0);
        chk("mid_rst_busy",    busy,        0);
        chk("mid_rst_note_on", note_on,     0);
        chk("mid_rst_phase",   dut.phase_r, 0);
        @(negedge clock) k_tr = 1'b1;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
